// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// The timeout watchdog is built only when MEM_ARB_TIMEOUT_EN is defined.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int TMO_CNT_W  = 8;
   localparam int BURST_W    = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_LS   = 2'd2
   } gnt_t;

   function automatic gnt_t state_to_gnt(input state_t s);
      case (s)
         FETCH:   return GNT_IF;
         DATA:    return GNT_LS;
         default: return GNT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Wait-state watchdog: counts cycles an access waits for ready and flags expiry
// on the TIMEOUT_CYC-th wait cycle. Instantiated only under MEM_ARB_TIMEOUT_EN.
module mem_arb_wdog
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic busy,
   input  logic ready,
   output logic expire
);

   logic [TMO_CNT_W-1:0] cnt_reg;

   assign expire = busy & ~ready & (cnt_reg == TMO_CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (start) begin
         cnt_reg <= '0;
      end else if (busy && !ready && !expire) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and load/store, LS first,
// with a burst limit against fetch starvation. Optional timeout: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int MAX_LS_BURST = 4,
   parameter int TIMEOUT_CYC  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_done,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall,
   output logic              err
);

   if (MAX_LS_BURST < 1 || MAX_LS_BURST > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_chk
      $error("mem_port_arbiter: parameter out of range");
   end

   state_t               state_reg;
   state_t               state_next;
   gnt_t                 gnt;
   logic [BURST_W-1:0]   burst_reg;
   logic                 burst_full;
   logic                 grant;
   logic                 expire;
   logic                 done_any;
   logic [DATA_W-1:0]    rdata_src;

   assign gnt        = state_to_gnt(state_reg);
   assign burst_full = (burst_reg == BURST_W'(MAX_LS_BURST));
   assign grant      = (state_reg == IDLE) && (state_next != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
   mem_arb_wdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_wdog (
      .clk   (clk),
      .rst   (rst),
      .start (grant),
      .busy  (mem_req),
      .ready (mem_ready),
      .expire(expire)
   );
   assign err = expire;
`else
   assign expire = 1'b0;
   assign err    = 1'b0;
`endif

   // A timed-out access completes like a normal one but returns all ones.
   assign done_any  = mem_req & (mem_ready | expire);
   assign rdata_src = mem_ready ? mem_rdata : '1;
   assign if_done   = done_any & (gnt == GNT_IF);
   assign ls_done   = done_any & (gnt == GNT_LS);
   assign if_rdata  = if_done ? rdata_src : '0;
   assign ls_rdata  = ls_done ? rdata_src : '0;
   assign stall     = rst & ((ls_req & ~ls_done) | (if_req & ~if_done));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (ls_req && !(if_req && burst_full)) begin
               state_next = DATA;
            end else if (if_req) begin
               state_next = FETCH;
            end
         end
         FETCH, DATA: begin
            if (done_any) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         burst_reg <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state_reg <= state_next;
         if (grant && state_next == DATA) begin
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
         end else if (grant) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
         end else if (done_any) begin
            mem_req   <= 1'b0;
         end
         if (!if_req || if_done) begin
            burst_reg <= '0;
         end else if (ls_done && !burst_full) begin
            burst_reg <= burst_reg + 1'b1;
         end
      end
   end

endmodule
